vc_input_buffer: RTL and testbench

Per-port virtual-channel input buffer sitting directly upstream of `input_router` in each RaveNoC router input port. Stores incoming flits in one FIFO per VC. Round-robin arbitrates among VCs at packet boundaries and locks onto one VC for a whole wormhole packet. Presents the selected head-of-line flit to `input_router` in its 37-bit request format and returns per-VC credits to the upstream link.

---
 rtl/vc_input_buffer.sv | 132 +++++++++++++
 tb/tb_vc_input_buffer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/vc_input_buffer.sv
// vc_input_buffer: per-VC flit FIFOs with round-robin arbitration that locks onto one VC per wormhole packet
// and returns one registered credit pulse per popped flit.
module vc_input_buffer #(
   parameter int N_VC       = 3,
   parameter int FIFO_DEPTH = 4,
   parameter int FLIT_W     = 34
) (
   input  logic              clk,
   input  logic              arst,
   input  logic              fin_valid_i,
   input  logic [1:0]        fin_vc_i,
   input  logic [FLIT_W-1:0] fin_flit_i,
   output logic [N_VC-1:0]   fin_credit_o,
   output logic [FLIT_W+2:0] flit_req_o,
   input  logic              flit_ready_i,
   output logic [N_VC-1:0]   vc_empty_o,
   output logic [N_VC-1:0]   vc_full_o,
   output logic              ovf_err_o
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic {IDLE, LOCKED} state_t;

   logic [FLIT_W-1:0] mem_q [N_VC][FIFO_DEPTH];
   logic [PW-1:0]     rd_ptr_q [N_VC];
   logic [PW-1:0]     rd_ptr_d [N_VC];
   logic [PW-1:0]     wr_ptr_q [N_VC];
   logic [PW-1:0]     wr_ptr_d [N_VC];
   logic [CW-1:0]     cnt_q [N_VC];
   logic [CW-1:0]     cnt_d [N_VC];
   state_t            state_q, state_d;
   logic [1:0]        rr_q, rr_d, lock_q, lock_d;
   logic [1:0]        cand, scan, sel;
   logic [N_VC-1:0]   credit_q, push_v, pop_v;
   logic              ovf_q, ovf_d;
   logic              req, pop, vc_ok, push_acc;
   logic [FLIT_W-1:0] head;
   logic [1:0]        head_type;

   function automatic logic [1:0] inc_vc(input logic [1:0] v);
      return (int'(v) == N_VC - 1) ? 2'd0 : v + 2'd1;
   endfunction

   always_comb begin
      for (int v = 0; v < N_VC; v++) begin
         vc_empty_o[v] = cnt_q[v] == '0;
         vc_full_o[v]  = cnt_q[v] == CW'(FIFO_DEPTH);
      end
   end

   // Scan downward so the lowest offset from rr_q wins.
   always_comb begin
      cand = rr_q;
      scan = '0;
      for (int i = N_VC - 1; i >= 0; i--) begin
         scan = 2'((int'(rr_q) + i) % N_VC);
         cand = vc_empty_o[scan] ? cand : scan;
      end
   end

   assign sel        = (state_q == LOCKED) ? lock_q : cand;
   assign req        = !vc_empty_o[sel];
   assign head       = mem_q[sel][rd_ptr_q[sel]];
   assign head_type  = head[FLIT_W-1 -: 2];
   assign flit_req_o = req ? {head, sel, 1'b1} : '0;
   assign pop        = req & flit_ready_i;
   assign vc_ok      = int'(fin_vc_i) < N_VC;
   // A full VC still accepts a push when it is being popped on the same edge.
   assign push_acc   = fin_valid_i & vc_ok &
                       ((cnt_q[fin_vc_i] != CW'(FIFO_DEPTH)) | (pop & (sel == fin_vc_i)));
   assign ovf_d      = ovf_q | (fin_valid_i & !push_acc);

   always_comb begin
      for (int v = 0; v < N_VC; v++) begin
         push_v[v]   = push_acc & (fin_vc_i == 2'(v));
         pop_v[v]    = pop & (sel == 2'(v));
         wr_ptr_d[v] = wr_ptr_q[v] + PW'(push_v[v]);
         rd_ptr_d[v] = rd_ptr_q[v] + PW'(pop_v[v]);
         cnt_d[v]    = cnt_q[v] + CW'(push_v[v]) - CW'(pop_v[v]);
      end
   end

   // Head flits take the lock; tail/single release it. Stray body/tail in IDLE pass through unlocked.
   always_comb begin
      state_d = state_q;
      rr_d    = rr_q;
      lock_d  = lock_q;
      if (pop && state_q == IDLE) begin
         rr_d    = inc_vc(cand);
         state_d = (head_type == 2'b00) ? LOCKED : IDLE;
         lock_d  = (head_type == 2'b00) ? cand : lock_q;
      end else if (pop && head_type[1]) begin
         rr_d    = inc_vc(lock_q);
         state_d = IDLE;
      end
   end

   always_ff @(posedge clk or negedge arst) begin
      if (!arst) begin
         for (int v = 0; v < N_VC; v++) begin
            rd_ptr_q[v] <= '0;
            wr_ptr_q[v] <= '0;
            cnt_q[v]    <= '0;
         end
         state_q  <= IDLE;
         rr_q     <= '0;
         lock_q   <= '0;
         credit_q <= '0;
         ovf_q    <= 1'b0;
      end else begin
         for (int v = 0; v < N_VC; v++) begin
            rd_ptr_q[v] <= rd_ptr_d[v];
            wr_ptr_q[v] <= wr_ptr_d[v];
            cnt_q[v]    <= cnt_d[v];
         end
         state_q  <= state_d;
         rr_q     <= rr_d;
         lock_q   <= lock_d;
         credit_q <= pop_v;
         ovf_q    <= ovf_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_acc) mem_q[fin_vc_i][wr_ptr_q[fin_vc_i]] <= fin_flit_i;
   end

   assign fin_credit_o = credit_q;
   assign ovf_err_o    = ovf_q;

endmodule

// File: tb/tb_vc_input_buffer.sv
// tb_vc_input_buffer: directed scenarios plus random traffic against a queue-based reference model.
module tb_vc_input_buffer;
   logic        clk = 1'b0;
   logic        arst = 1'b0;
   logic        fin_valid_i = 1'b0;
   logic [1:0]  fin_vc_i = '0;
   logic [33:0] fin_flit_i = '0;
   logic [2:0]  fin_credit_o;
   logic [36:0] flit_req_o;
   logic        flit_ready_i = 1'b0;
   logic [2:0]  vc_empty_o;
   logic [2:0]  vc_full_o;
   logic        ovf_err_o;

   int n_checks = 0;
   int n_err = 0;

   logic [33:0] mq [3][$];
   int          m_rr;
   int          m_lk;
   bit          m_ovf;
   logic [2:0]  m_cred;

   always #5 clk = ~clk;

   vc_input_buffer dut (
      .clk          (clk),
      .arst         (arst),
      .fin_valid_i  (fin_valid_i),
      .fin_vc_i     (fin_vc_i),
      .fin_flit_i   (fin_flit_i),
      .fin_credit_o (fin_credit_o),
      .flit_req_o   (flit_req_o),
      .flit_ready_i (flit_ready_i),
      .vc_empty_o   (vc_empty_o),
      .vc_full_o    (vc_full_o),
      .ovf_err_o    (ovf_err_o)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [33:0] fl(input logic [1:0] t, input int d);
      return {t, 32'(d)};
   endfunction

   function automatic void model_present(output int pv, output bit r);
      pv = m_rr;
      r  = 1'b0;
      if (m_lk >= 0) begin
         pv = m_lk;
         r  = mq[m_lk].size() != 0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            int v = (m_rr + i) % 3;
            if (!r && mq[v].size() != 0) begin
               pv = v;
               r  = 1'b1;
            end
         end
      end
   endfunction

   task automatic do_reset();
      arst = 1'b0;
      fin_valid_i = 1'b0;
      flit_ready_i = 1'b0;
      #1;
      chk("rst_req", flit_req_o, 37'd0);
      chk("rst_empty", vc_empty_o, 3'b111);
      chk("rst_full", vc_full_o, 3'b000);
      chk("rst_ovf", ovf_err_o, 1'b0);
      chk("rst_credit", fin_credit_o, 3'b000);
      for (int i = 0; i < 3; i++) mq[i].delete();
      m_rr = 0;
      m_lk = -1;
      m_ovf = 1'b0;
      m_cred = '0;
      @(posedge clk);
      @(negedge clk);
      arst = 1'b1;
   endtask

   // Called at a falling edge: drive, compare against the model, advance the model, cross one rising edge.
   task automatic step(input bit v, input logic [1:0] vc, input logic [33:0] f, input bit rdy);
      int pv;
      bit r;
      bit acc;
      logic [36:0] er;
      logic [2:0] ee, ef;
      logic [33:0] h;
      fin_valid_i = v;
      fin_vc_i = vc;
      fin_flit_i = f;
      flit_ready_i = rdy;
      #1;
      model_present(pv, r);
      er = r ? {mq[pv][0], 2'(pv), 1'b1} : 37'd0;
      for (int i = 0; i < 3; i++) begin
         ee[i] = mq[i].size() == 0;
         ef[i] = mq[i].size() == 4;
      end
      chk("flit_req", flit_req_o, er);
      chk("vc_empty", vc_empty_o, ee);
      chk("vc_full", vc_full_o, ef);
      chk("ovf_err", ovf_err_o, m_ovf);
      chk("credit", fin_credit_o, m_cred);
      acc = 1'b0;
      if (v && vc < 3) acc = mq[vc].size() < 4 || (r && rdy && pv == int'(vc));
      m_cred = '0;
      if (r && rdy) begin
         h = mq[pv].pop_front();
         m_cred = 3'(1 << pv);
         if (m_lk < 0) begin
            m_rr = (pv + 1) % 3;
            if (h[33:32] == 2'b00) m_lk = pv;
         end else if (h[33]) begin
            m_lk = -1;
            m_rr = (pv + 1) % 3;
         end
      end
      if (acc) mq[vc].push_back(f);
      else if (v) m_ovf = 1'b1;
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      int ncred;
      int nflit;
      logic [1:0] ty [4];
      ty = '{2'b00, 2'b01, 2'b01, 2'b10};
      do_reset();

      // reset in the middle of traffic with a credit pending
      step(1, 0, fl(0, 1), 0);
      step(1, 1, fl(3, 2), 1);
      do_reset();
      step(0, 0, '0, 1);
      chk("rst_no_credit", fin_credit_o, 3'b000);

      // single VC packet, one flit per cycle
      do_reset();
      ncred = 0;
      for (int i = 0; i < 6; i++) begin
         if (i < 4) step(1, 1, fl(ty[i], i + 1), 1);
         else step(0, 0, '0, 1);
         if (i < 4) chk("sv_flit", flit_req_o, {fl(ty[i], i + 1), 2'd1, 1'b1});
         if (fin_credit_o == 3'b010) ncred++;
      end
      chk("sv_credits", ncred, 4);

      // wormhole lock blocks VC2 until the VC0 tail arrives
      do_reset();
      step(1, 0, fl(0, 16), 0);
      step(1, 0, fl(1, 17), 0);
      step(1, 2, fl(3, 32), 0);
      step(0, 0, '0, 1);
      step(0, 0, '0, 1);
      chk("wh_stall", flit_req_o[0], 1'b0);
      chk("wh_vc2_held", vc_empty_o[2], 1'b0);
      step(0, 0, '0, 1);
      step(1, 0, fl(2, 18), 1);
      chk("wh_tail", flit_req_o, {fl(2, 18), 2'd0, 1'b1});
      step(0, 0, '0, 1);
      chk("wh_vc2_next", flit_req_o, {fl(3, 32), 2'd2, 1'b1});
      step(0, 0, '0, 1);

      // round-robin order over two refills
      do_reset();
      for (int rnd = 0; rnd < 2; rnd++) begin
         for (int v = 0; v < 3; v++) step(1, 2'(v), fl(3, v), 0);
         for (int k = 0; k < 3; k++) begin
            chk("rr_order", {flit_req_o[0], flit_req_o[2:1]}, {1'b1, 2'(k)});
            step(0, 0, '0, 1);
         end
      end

      // overflow on VC2 and sticky error
      do_reset();
      for (int i = 0; i < 5; i++) begin
         step(1, 2, fl(3, 100 + i), 0);
         if (i == 3) chk("ovf_full", vc_full_o[2], 1'b1);
      end
      chk("ovf_set", ovf_err_o, 1'b1);
      ncred = 0;
      nflit = 0;
      for (int i = 0; i < 7; i++) begin
         if (flit_req_o[0]) nflit++;
         step(0, 0, '0, 1);
         if (fin_credit_o[2]) ncred++;
      end
      chk("ovf_drain_flits", nflit, 4);
      chk("ovf_drain_credits", ncred, 4);
      chk("ovf_sticky", ovf_err_o, 1'b1);

      // full VC accepts a push when popped on the same edge
      do_reset();
      for (int i = 0; i < 4; i++) step(1, 0, fl(3, i), 0);
      step(1, 0, fl(3, 9), 1);
      chk("fs_full", vc_full_o[0], 1'b1);
      chk("fs_no_ovf", ovf_err_o, 1'b0);

      // random traffic with occasional resets and invalid VCs
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         bit v;
         bit rdy;
         logic [1:0] vc;
         logic [33:0] f;
         if ($urandom % 400 == 0) do_reset();
         v = ($urandom % 10) < 7;
         vc = ($urandom % 40 == 0) ? 2'd3 : 2'($urandom % 3);
         f = {2'($urandom), 32'($urandom)};
         rdy = ($urandom % 10) < 6;
         step(v, vc, f, rdy);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end
endmodule
